// File: rtl/count_monitor_pkg.sv
// Shared constants for count_monitor: counter width, event record layout, match FSM states.
package count_monitor_pkg;

  localparam int COUNT_W   = 4;
  localparam int FLAG_W    = 3;

  // Flag bit positions within the 3-bit flag field of an event record
  localparam int CLR_BIT   = 2;
  localparam int WRAP_BIT  = 1;
  localparam int MATCH_BIT = 0;

  // Record layout: {flags[FLAG_W-1:0], wraps[WRAP_W-1:0]}
  localparam int WRAPS_LSB = 0;

  function automatic int flags_lsb(input int wrap_w);
    return WRAPS_LSB + wrap_w;
  endfunction

  typedef enum logic {IDLE, ARMED} match_state_t;

endpackage

// File: rtl/event_fifo.sv
// Generic synchronous FIFO, registered write, combinational head read (zero when empty).
// Push while full is accepted only if a pop happens in the same cycle; otherwise the caller sees full.
module event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (rd_en) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/count_monitor.sv
// Extends a 4-bit counter with a wrap count and queues clear/wrap/match events; one-cycle latency.
// Events drain over evt_valid/evt_ready; a push into a full FIFO with no pop is dropped and sets sticky overrun. Match logic: COUNT_MONITOR_MATCH_EN.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int WRAP_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic                      clock,
  input  logic                      clear_n,
  input  logic [COUNT_W-1:0]        count_in,
  input  logic [COUNT_W-1:0]        match_val,
  input  logic                      arm,
  output logic [WRAP_W+COUNT_W-1:0] ext_count,
  output logic [WRAP_W-1:0]         wraps,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [WRAP_W+FLAG_W-1:0]  evt_data,
  output logic                      overrun,
  output logic                      armed
);

  localparam int FLAGS_LSB = flags_lsb(WRAP_W);

  logic [COUNT_W-1:0]       prev;
  logic [WRAP_W-1:0]        wraps_nxt;
  logic [WRAP_W+FLAG_W-1:0] record;
  logic                     wrap_det;
  logic                     clr_det;
  logic                     match_det;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;

  assign wrap_det = (prev == {COUNT_W{1'b1}}) && (count_in == '0);
  assign clr_det  = (count_in == '0) && (prev != '0) && (prev != {COUNT_W{1'b1}});

`ifdef COUNT_MONITOR_MATCH_EN
  match_state_t state;
  match_state_t state_nxt;

  // count_in != prev keeps the value present at arm time from matching
  assign match_det = (state == ARMED) && (count_in != prev) && (count_in == match_val);
  assign armed     = (state == ARMED);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm)       state_nxt = ARMED;
      ARMED:   if (match_det) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
`else
  logic unused_match_inputs;
  assign unused_match_inputs = ^{arm, match_val};
  assign match_det = 1'b0;
  assign armed     = 1'b0;
`endif

  always_comb begin
    wraps_nxt = wraps;
    if (clr_det)       wraps_nxt = '0;
    else if (wrap_det) wraps_nxt = wraps + {{(WRAP_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    record = '0;
    record[WRAPS_LSB +: WRAP_W]        = wraps_nxt;
    record[FLAGS_LSB + CLR_BIT]   = clr_det;
    record[FLAGS_LSB + WRAP_BIT]  = wrap_det;
    record[FLAGS_LSB + MATCH_BIT] = match_det;
  end

  assign push      = wrap_det || clr_det || match_det;
  assign evt_valid = !empty;
  assign pop       = evt_valid && evt_ready;
  assign ext_count = {wraps, prev};

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      prev    <= '0;
      wraps   <= '0;
      overrun <= 1'b0;
    end else begin
      prev  <= count_in;
      wraps <= wraps_nxt;
      if (push && full && !pop) overrun <= 1'b1;
    end
  end

  event_fifo #(
    .WIDTH (WRAP_W + FLAG_W),
    .DEPTH (DEPTH)
  ) u_event_fifo (
    .clock     (clock),
    .clear_n   (clear_n),
    .push      (push),
    .push_data (record),
    .pop       (pop),
    .pop_data  (evt_data),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: stimulus pushes expected event records, a negedge monitor pops and compares on each handshake.
module tb_count_monitor;

  localparam int WRAP_W = 12;
  localparam int DEPTH  = 4;
`ifdef COUNT_MONITOR_MATCH_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                clear_n;
  logic [3:0]          count_in;
  logic [3:0]          match_val;
  logic                arm;
  logic [WRAP_W+3:0]   ext_count;
  logic [WRAP_W-1:0]   wraps;
  logic                evt_valid;
  logic                evt_ready;
  logic [WRAP_W+2:0]   evt_data;
  logic                overrun;
  logic                armed;

  int checks = 0;
  int errors = 0;
  logic [WRAP_W+2:0] exp_q [$];

  always #5 clock = ~clock;

  count_monitor #(.WRAP_W(WRAP_W), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .count_in  (count_in),
    .match_val (match_val),
    .arm       (arm),
    .ext_count (ext_count),
    .wraps     (wraps),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .overrun   (overrun),
    .armed     (armed)
  );

  function automatic logic [WRAP_W+2:0] rec(input bit c, input bit w, input bit m, input logic [WRAP_W-1:0] wr);
    return {c, w, m, wr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted record must match the oldest expected one
  always @(negedge clock) begin
    if (clear_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL evt_unexpected: got %h expected none", evt_data);
      end else begin
        check("evt_data", 32'(evt_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic set_count(input logic [3:0] v);
    @(posedge clock); #1;
    count_in = v;
  endtask

  task automatic step_up(input int from, input int to);
    for (int v = from; v <= to; v++) set_count(4'(v));
  endtask

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic drain;
    int n = 0;
    while (exp_q.size() > 0 && n < 60) begin
      @(posedge clock);
      n++;
    end
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic apply_reset;
    @(posedge clock); #1;
    clear_n  = 1'b0;
    count_in = 4'h0;
    arm      = 1'b0;
    exp_q.delete();
    #2;
    check("rst_ext_count", 32'(ext_count), 32'h0);
    check("rst_wraps",     32'(wraps),     32'h0);
    check("rst_evt_valid", 32'(evt_valid), 32'h0);
    check("rst_evt_data",  32'(evt_data),  32'h0);
    check("rst_overrun",   32'(overrun),   32'h0);
    check("rst_armed",     32'(armed),     32'h0);
    @(posedge clock); #1;
    clear_n = 1'b1;
  endtask

  initial begin
    clear_n   = 1'b0;
    count_in  = 4'h0;
    match_val = 4'h0;
    arm       = 1'b0;
    evt_ready = 1'b1;
    apply_reset();

    // Full pass 0..15,0: one wrap record, ext_count becomes 0x0010
    step_up(1, 15);
    set_count(4'h0);
    exp_q.push_back(rec(0, 1, 0, 12'd1));
    tick();
    check("wrap_ext_count", 32'(ext_count), 32'h0010);
    check("wrap_wraps",     32'(wraps),     32'h1);

    // Clear from 7 resets wraps
    step_up(1, 7);
    set_count(4'h0);
    exp_q.push_back(rec(1, 0, 0, 12'd0));
    tick();
    check("clr_wraps",     32'(wraps),     32'h0);
    check("clr_ext_count", 32'(ext_count), 32'h0);

    // One-shot match at 5 armed while count sits at 3
    match_val = 4'h5;
    step_up(1, 3);
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("arm_armed", 32'(armed), 32'(EN));
    set_count(4'h4);
    set_count(4'h5);
    if (EN) exp_q.push_back(rec(0, 0, 1, 12'd0));
    tick();
    check("match_disarm", 32'(armed), 32'h0);
    step_up(6, 15);
    set_count(4'h0);
    exp_q.push_back(rec(0, 1, 0, 12'd1));
    step_up(1, 5);
    set_count(4'h0);
    exp_q.push_back(rec(1, 0, 0, 12'd0));
    drain();

    // match_val=0 coinciding with wrap: single record carrying both flags
    match_val = 4'h0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("arm0_armed", 32'(armed), 32'(EN));
    step_up(1, 15);
    set_count(4'h0);
    exp_q.push_back(rec(0, 1, EN, 12'd1));
    tick();
    check("wrapmatch_armed", 32'(armed), 32'h0);
    set_count(4'h1);
    set_count(4'h0);
    exp_q.push_back(rec(1, 0, 0, 12'd0));
    drain();

    // Overrun: DEPTH+1 wraps with consumer stalled
    evt_ready = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      step_up(1, 15);
      set_count(4'h0);
      if (i <= DEPTH) exp_q.push_back(rec(0, 1, 0, 12'(i)));
    end
    tick();
    check("ovr_overrun",   32'(overrun),   32'h1);
    check("ovr_evt_valid", 32'(evt_valid), 32'h1);
    check("ovr_ext_count", 32'(ext_count), 32'h0050);
    evt_ready = 1'b1;
    drain();
    apply_reset();

    // Full FIFO with a pop in the same cycle as the push: nothing lost
    evt_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      step_up(1, 15);
      set_count(4'h0);
      exp_q.push_back(rec(0, 1, 0, 12'(i)));
    end
    step_up(1, 15);
    @(posedge clock); #1;
    count_in  = 4'h0;
    evt_ready = 1'b1;
    exp_q.push_back(rec(0, 1, 0, 12'(DEPTH + 1)));
    tick();
    check("popfull_overrun", 32'(overrun), 32'h0);
    drain();

    // Mid-stream reset discards a pending record
    evt_ready = 1'b0;
    step_up(1, 15);
    set_count(4'h0);
    exp_q.push_back(rec(0, 1, 0, 12'(DEPTH + 2)));
    set_count(4'h3);
    tick();
    check("pre_rst_evt_valid", 32'(evt_valid), 32'h1);
    apply_reset();
    evt_ready = 1'b1;
    set_count(4'h1);
    set_count(4'h0);
    exp_q.push_back(rec(1, 0, 0, 12'd0));
    drain();
    check("end_overrun", 32'(overrun), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
